// File: rtl/me_sad_min_select.sv
// me_sad_min_select
//   Minimum-SAD decision unit for the motion-estimation datapath. For each
//   of the four coding sub-blocks it tracks the smallest SAD seen during a
//   CU search and the search position (col,row) that produced it. When the
//   search finishes, it drains the four winners, one word per handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: begin a new CU search (also aborts one in flight)
//   sad_valid/sad_cb/sad_value/sad_col/sad_row   SAD sample stream
//   search_done       pulse: last SAD of the CU has been presented
//   out_valid/out_ready, out_cb/out_sad/out_col/out_row/out_hit  result words
//   cu_done           pulse, one cycle after the final result word is accepted
//   overrun           sticky: a sample arrived outside SEARCH; cleared by start

// One best-candidate slot: holds the running minimum for one sub-block.
module me_sad_min_slot #(
   parameter int SAD_W = 16,
   parameter int COL_W = 5,
   parameter int ROW_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             upd,
   input  logic [SAD_W-1:0] sad_value,
   input  logic [COL_W-1:0] sad_col,
   input  logic [ROW_W-1:0] sad_row,
   output logic [SAD_W-1:0] best_sad,
   output logic [COL_W-1:0] best_col,
   output logic [ROW_W-1:0] best_row,
   output logic             hit
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_sad <= '1;
         best_col <= '0;
         best_row <= '0;
         hit      <= 1'b0;
      end else if (clr) begin
         best_sad <= '1;
         best_col <= '0;
         best_row <= '0;
         hit      <= 1'b0;
      end else if (upd) begin
         hit <= 1'b1;
         // Strict compare: on a tie the earlier position is kept.
         if (sad_value < best_sad) begin
            best_sad <= sad_value;
            best_col <= sad_col;
            best_row <= sad_row;
         end
      end
   end
endmodule

module me_sad_min_select #(
   parameter int SAD_W = 16,
   parameter int COL_W = 5,
   parameter int ROW_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sad_valid,
   input  logic [1:0]       sad_cb,
   input  logic [SAD_W-1:0] sad_value,
   input  logic [COL_W-1:0] sad_col,
   input  logic [ROW_W-1:0] sad_row,
   input  logic             search_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_cb,
   output logic [SAD_W-1:0] out_sad,
   output logic [COL_W-1:0] out_col,
   output logic [ROW_W-1:0] out_row,
   output logic             out_hit,
   output logic             cu_done,
   output logic             overrun
);
   localparam int NUM_CB = 4;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;

   logic [1:0] state, state_nxt;
   logic [1:0] idx;

   logic [NUM_CB-1:0][SAD_W-1:0] best_sad;
   logic [NUM_CB-1:0][COL_W-1:0] best_col;
   logic [NUM_CB-1:0][ROW_W-1:0] best_row;
   logic [NUM_CB-1:0]            best_hit;
   logic [NUM_CB-1:0]            upd;

   logic in_search, in_drain, accept, hs;

   assign in_search = (state == S_SEARCH);
   assign in_drain  = (state == S_DRAIN);
   // start has priority over any sample in the same cycle.
   assign accept    = sad_valid && in_search && !start;
   assign hs        = in_drain && out_ready;

   genvar k;
   generate
      for (k = 0; k < NUM_CB; k++) begin : g_slot
         assign upd[k] = accept && (sad_cb == 2'(k));
         me_sad_min_slot #(.SAD_W(SAD_W), .COL_W(COL_W), .ROW_W(ROW_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (start),
            .upd       (upd[k]),
            .sad_value (sad_value),
            .sad_col   (sad_col),
            .sad_row   (sad_row),
            .best_sad  (best_sad[k]),
            .best_col  (best_col[k]),
            .best_row  (best_row[k]),
            .hit       (best_hit[k])
         );
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_SEARCH;
      end else begin
         case (state)
            S_IDLE:   state_nxt = S_IDLE;
            S_SEARCH: if (search_done) state_nxt = S_DRAIN;
            S_DRAIN:  if (out_ready && idx == 2'd3) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= 2'd0;
         cu_done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         cu_done <= !start && hs && (idx == 2'd3);
         // idx wraps from 3 to 0 on the last handshake, ready for the next CU.
         if (start || (in_search && search_done))
            idx <= 2'd0;
         else if (hs)
            idx <= idx + 2'd1;
         if (start)
            overrun <= 1'b0;
         else if (sad_valid && !in_search)
            overrun <= 1'b1;
      end
   end

   // Slots are frozen during DRAIN, so the muxed fields stay stable under
   // backpressure without a separate output register.
   assign out_valid = in_drain;
   assign out_cb    = idx;
   assign out_sad   = best_sad[idx];
   assign out_col   = best_col[idx];
   assign out_row   = best_row[idx];
   assign out_hit   = best_hit[idx];
endmodule
